// File: rtl/mb_crc_serdes.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mb_crc_serdes : CRC-protected serializer (TX) and independent checking
//                 deserializer (RX), serial LFSR CRC, MSB first.  Rev 1.0
// ---------------------------------------------------------------------------
module mb_crc_serdes #(
  parameter int               DATA_W = 8,
  parameter int               CRC_W  = 3,
  parameter logic [CRC_W-1:0] POLY   = 3'b011
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              Load,
  input  logic [DATA_W-1:0] Data_in,
  output logic              Busy,
  output logic              Data_out,
  output logic              Tx_done,
  input  logic              Rx_en,
  input  logic              Serial_In,
  output logic [DATA_W-1:0] Rx_data,
  output logic              Rx_done,
  output logic              ERROR
);

  localparam int FRAME_W = DATA_W + CRC_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CRC_LAST   = CNT_W'(CRC_W);
  localparam logic [CNT_W-1:0] CRC_PRE    = CNT_W'(CRC_W - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, DATA, CRC} tx_state_t;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                input logic din);
    logic fb;
    fb = crc[CRC_W-1] ^ din;
    crc_step = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  tx_state_t         tx_state;
  logic [DATA_W-1:0] tx_shift;
  logic [CRC_W-1:0]  tx_crc;
  logic [CNT_W-1:0]  tx_cnt;
  logic              tx_accept;

  // The closing edge of the last CRC bit also accepts a new frame, so
  // back-to-back frames run with no idle gap.
  assign tx_accept = Load && ((tx_state == IDLE) ||
                              (tx_state == CRC && tx_cnt == CRC_LAST));

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      tx_state <= IDLE;
      tx_shift <= '0;
      tx_crc   <= '0;
      tx_cnt   <= '0;
      Busy     <= 1'b0;
      Data_out <= 1'b0;
      Tx_done  <= 1'b0;
    end else begin
      Tx_done <= 1'b0;
      if (tx_accept) begin
        // First payload bit goes out immediately; tx_cnt counts bits emitted.
        tx_state <= DATA;
        Busy     <= 1'b1;
        Data_out <= Data_in[DATA_W-1];
        tx_shift <= {Data_in[DATA_W-2:0], 1'b0};
        tx_crc   <= crc_step('0, Data_in[DATA_W-1]);
        tx_cnt   <= CNT_W'(1);
      end else begin
        case (tx_state)
          IDLE: begin
            Busy     <= 1'b0;
            Data_out <= 1'b0;
          end
          DATA: begin
            if (tx_cnt == DATA_LAST) begin
              tx_state <= CRC;
              Data_out <= tx_crc[CRC_W-1];
              tx_crc   <= {tx_crc[CRC_W-2:0], 1'b0};
              tx_cnt   <= CNT_W'(1);
            end else begin
              Data_out <= tx_shift[DATA_W-1];
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              tx_crc   <= crc_step(tx_crc, tx_shift[DATA_W-1]);
              tx_cnt   <= tx_cnt + 1'b1;
            end
          end
          CRC: begin
            if (tx_cnt == CRC_LAST) begin
              tx_state <= IDLE;
              Busy     <= 1'b0;
              Data_out <= 1'b0;
              tx_cnt   <= '0;
            end else begin
              Data_out <= tx_crc[CRC_W-1];
              tx_crc   <= {tx_crc[CRC_W-2:0], 1'b0};
              tx_cnt   <= tx_cnt + 1'b1;
              Tx_done  <= (tx_cnt == CRC_PRE);
            end
          end
          default: begin
            tx_state <= IDLE;
            Busy     <= 1'b0;
            Data_out <= 1'b0;
          end
        endcase
      end
    end
  end

  logic [CNT_W-1:0]  rx_cnt;
  logic [CRC_W-1:0]  rx_crc;
  logic [CRC_W-1:0]  rx_next;
  logic [DATA_W-1:0] rx_shift;

  assign rx_next = crc_step(rx_crc, Serial_In);

  // A good frame (payload followed by its CRC) leaves a zero remainder.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      rx_cnt   <= '0;
      rx_crc   <= '0;
      rx_shift <= '0;
      Rx_data  <= '0;
      Rx_done  <= 1'b0;
      ERROR    <= 1'b0;
    end else begin
      Rx_done <= 1'b0;
      if (Rx_en) begin
        if (rx_cnt < DATA_LAST) begin
          rx_shift <= {rx_shift[DATA_W-2:0], Serial_In};
        end
        if (rx_cnt == FRAME_LAST) begin
          Rx_done <= 1'b1;
          Rx_data <= rx_shift;
          ERROR   <= (rx_next != '0);
          rx_cnt  <= '0;
          rx_crc  <= '0;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
          rx_crc <= rx_next;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mb_crc_serdes.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mb_crc_serdes : directed and randomized bench with a frame-level model
//                    (polynomial long division, bit queues).  Rev 1.0
// ---------------------------------------------------------------------------
module tb_mb_crc_serdes;

  localparam int DW = 8;
  localparam int CW = 3;
  localparam int FW = DW + CW;
  localparam logic [CW-1:0] POLY = 3'b011;

  logic          CLK = 1'b0;
  logic          CLR = 1'b0;
  logic          Load = 1'b0;
  logic [DW-1:0] Data_in = '0;
  logic          Rx_en = 1'b0;
  logic          Serial_In = 1'b0;
  logic          Busy, Data_out, Tx_done, Rx_done, ERROR;
  logic [DW-1:0] Rx_data;

  int errors = 0;
  int checks = 0;

  bit            txq[$];
  bit            rxq[$];
  logic          m_rx_done = 1'b0;
  logic [DW-1:0] m_rx_data = '0;
  logic          m_err = 1'b0;

  mb_crc_serdes #(.DATA_W(DW), .CRC_W(CW), .POLY(POLY)) dut (
    .CLK(CLK), .CLR(CLR), .Load(Load), .Data_in(Data_in),
    .Busy(Busy), .Data_out(Data_out), .Tx_done(Tx_done),
    .Rx_en(Rx_en), .Serial_In(Serial_In),
    .Rx_data(Rx_data), .Rx_done(Rx_done), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Remainder of payload * x^CW divided by x^CW + POLY (GF(2) long division).
  function automatic logic [CW-1:0] crc_div(input logic [DW-1:0] d);
    logic [FW-1:0] v;
    logic [CW:0]   g;
    v = {d, {CW{1'b0}}};
    g = {1'b1, POLY};
    for (int i = FW - 1; i >= CW; i--)
      if (v[i]) v[i -: CW+1] = v[i -: CW+1] ^ g;
    return v[CW-1:0];
  endfunction

  task automatic push_frame(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    c = crc_div(d);
    for (int i = DW - 1; i >= 0; i--) txq.push_back(d[i]);
    for (int i = CW - 1; i >= 0; i--) txq.push_back(c[i]);
  endtask

  task automatic model_clear();
    txq.delete();
    rxq.delete();
    m_rx_done = 1'b0;
    m_rx_data = '0;
    m_err     = 1'b0;
  endtask

  // Frame-level view: txq front is the bit on the line this cycle.
  task automatic model_edge();
    int old;
    logic [DW-1:0] pay;
    logic [CW-1:0] rcv;
    if (!CLR) begin
      model_clear();
    end else begin
      old = txq.size();
      if (old > 0) void'(txq.pop_front());
      if (old <= 1 && Load) push_frame(Data_in);
      m_rx_done = 1'b0;
      if (Rx_en) begin
        rxq.push_back(Serial_In);
        if (rxq.size() == FW) begin
          for (int i = 0; i < DW; i++) pay[DW-1-i] = rxq[i];
          for (int i = 0; i < CW; i++) rcv[CW-1-i] = rxq[DW+i];
          m_rx_data = pay;
          m_err     = (crc_div(pay) != rcv);
          m_rx_done = 1'b1;
          rxq.delete();
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("busy",     Busy,     (txq.size() > 0));
    chk("data_out", Data_out, (txq.size() > 0) ? txq[0] : 1'b0);
    chk("tx_done",  Tx_done,  (txq.size() == 1));
    chk("rx_done",  Rx_done,  m_rx_done);
    chk("rx_data",  Rx_data,  m_rx_data);
    chk("error",    ERROR,    m_err);
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_all();
  endtask

  // Called at a negedge: asserts CLR mid-cycle, checks outputs clear at once.
  task automatic do_reset();
    #3 CLR = 1'b0;
    #1;
    chk("rst_async_busy",    Busy,     0);
    chk("rst_async_dout",    Data_out, 0);
    chk("rst_async_txdone",  Tx_done,  0);
    chk("rst_async_rxdone",  Rx_done,  0);
    chk("rst_async_rxdata",  Rx_data,  0);
    chk("rst_async_error",   ERROR,    0);
    model_clear();
    @(posedge CLK);
    @(negedge CLK);
    compare_all();
    CLR = 1'b1;
  endtask

  // Loopback frame with literal expectations on the serial sequence and result.
  task automatic loop_frame(input string tag, input logic [DW-1:0] d, input logic [FW-1:0] exp_seq);
    logic [FW-1:0] seq;
    int busy_cnt;
    seq = '0;
    busy_cnt = 0;
    Data_in = d; Load = 1'b1; Rx_en = 1'b0;
    step();
    Load = 1'b0;
    for (int i = 0; i < FW; i++) begin
      seq = {seq[FW-2:0], Data_out};
      busy_cnt += int'(Busy);
      if (i == FW - 1) chk({tag, "_txdone_last"}, Tx_done, 1);
      Rx_en = Busy; Serial_In = Data_out;
      step();
    end
    Rx_en = 1'b0;
    chk({tag, "_seq"},     seq, exp_seq);
    chk({tag, "_busy"},    busy_cnt, FW);
    chk({tag, "_rx_done"}, Rx_done, 1);
    chk({tag, "_rx_data"}, Rx_data, d);
    chk({tag, "_error"},   ERROR, 0);
    chk({tag, "_idle"},    Busy, 0);
  endtask

  task automatic rx_stream(input logic [FW-1:0] s);
    Rx_en = 1'b1;
    for (int i = FW - 1; i >= 0; i--) begin
      Serial_In = s[i];
      step();
    end
    Rx_en = 1'b0;
  endtask

  initial begin
    logic [2*FW-1:0] seq2;
    int busy_cnt;
    int done_at;
    logic [FW-1:0] a5_frame;
    bit loop_mode;

    a5_frame = 11'b10100101_101;

    // Reset state and model anchors
    @(negedge CLK);
    compare_all();
    chk("model_crc_a5", crc_div(8'hA5), 3'b101);
    chk("model_crc_3c", crc_div(8'h3C), 3'b001);
    chk("model_crc_00", crc_div(8'h00), 3'b000);
    CLR = 1'b1;
    step();

    loop_frame("a5", 8'hA5, a5_frame);

    // Corrupted last CRC bit, then a clean all-zero frame
    rx_stream(11'b10100101_100);
    chk("bad_rx_done", Rx_done, 1);
    chk("bad_rx_data", Rx_data, 8'hA5);
    chk("bad_error",   ERROR, 1);
    step();
    rx_stream(11'b0);
    chk("zero_rx_done", Rx_done, 1);
    chk("zero_rx_data", Rx_data, 8'h00);
    chk("zero_error",   ERROR, 0);

    // Load held high: two contiguous frames, intermediate Loads ignored
    seq2 = '0; busy_cnt = 0;
    Data_in = 8'hA5; Load = 1'b1;
    step();
    Data_in = 8'h3C;
    for (int i = 0; i < 2 * FW; i++) begin
      seq2 = {seq2[2*FW-2:0], Data_out};
      busy_cnt += int'(Busy);
      step();
      if (i >= FW) Load = 1'b0;
    end
    chk("b2b_seq",  seq2, {a5_frame, 11'b00111100_001});
    chk("b2b_busy", busy_cnt, 2 * FW);
    chk("b2b_idle", Busy, 0);

    // Rx_en toggled every cycle; junk on Serial_In while stalled
    done_at = -1;
    for (int i = 0; i < 2 * FW; i++) begin
      Rx_en = (i % 2 == 0);
      Serial_In = Rx_en ? a5_frame[FW-1-i/2] : 1'($urandom_range(0, 1));
      step();
      if (Rx_done && done_at < 0) done_at = i + 1;
    end
    Rx_en = 1'b0;
    chk("stall_done_step", done_at, 2 * FW - 1);
    chk("stall_rx_data",   Rx_data, 8'hA5);
    chk("stall_error",     ERROR, 0);

    // Reset in the middle of a loopback frame, then a full clean frame
    Data_in = 8'hA5; Load = 1'b1;
    step();
    Load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Rx_en = Busy; Serial_In = Data_out;
      step();
    end
    Rx_en = 1'b0;
    do_reset();
    step();
    loop_frame("post_rst", 8'hA5, a5_frame);

    // Randomized traffic: loopback and free-running RX, sporadic resets
    for (int c = 0; c < 600; c++) begin
      loop_mode = ((c / 100) % 2 == 0);
      Load = ($urandom_range(0, 3) == 0);
      Data_in = DW'($urandom);
      if (loop_mode) begin
        Rx_en = Busy; Serial_In = Data_out;
      end else begin
        Rx_en = 1'($urandom_range(0, 1));
        Serial_In = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 96) == 0) begin
        Load = 1'b0;
        do_reset();
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
